// File: rtl/console_csr_slave.sv
// console_csr_slave: Avalon-MM CSR bank fed by the JTAG Avalon master.
// NUM_REGS 32-bit registers with byte-lane writes, a fixed-latency pipelined read path
// and a registered post-reset waitrequest window. Register 0 drives ctrl_out; the top
// two registers are a free-running cycle counter and a constant ID.
// Build macro CONSOLE_CSR_ERRCNT_EN: adds a 16-bit saturating out-of-range access
// counter at index NUM_REGS-3 (read-only; any write clears it).
module console_csr_slave #(
    parameter int unsigned NUM_REGS     = 16,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned INIT_CYCLES  = 8,
    parameter logic [31:0] ID_VALUE     = 32'hC0A5_0001
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] address,
    input  logic [3:0]  byteenable,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        waitrequest,
    output logic [31:0] ctrl_out
);

    localparam int unsigned      IDX_W     = $clog2(NUM_REGS);
    localparam logic [31:0]      SPAN_MASK = 32'(NUM_REGS * 4 - 1);
    localparam logic [IDX_W-1:0] ID_IDX    = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] CNT_IDX   = IDX_W'(NUM_REGS - 2);
`ifdef CONSOLE_CSR_ERRCNT_EN
    localparam logic [IDX_W-1:0] ERR_IDX   = IDX_W'(NUM_REGS - 3);
    localparam int unsigned      NUM_RW    = NUM_REGS - 3;
`else
    localparam int unsigned      NUM_RW    = NUM_REGS - 2;
`endif

    logic [31:0]             regs [NUM_RW];
    logic [7:0]              init_cnt;
    logic [31:0]             cycle_cnt;
    logic [31:0]             pipe_data [READ_LATENCY];
    logic [READ_LATENCY-1:0] pipe_vld;

    logic             in_range_c;
    logic [IDX_W-1:0] index_c;
    logic             wr_acc_c;
    logic             rd_acc_c;
    logic [31:0]      rd_data_c;

`ifdef CONSOLE_CSR_ERRCNT_EN
    logic [15:0]      err_cnt;
`endif

    // Address decode and request acceptance; a write wins over a simultaneous read
    always_comb begin
        in_range_c = ((address & ~SPAN_MASK) == BASE_ADDR);
        index_c    = address[IDX_W+1:2];
        wr_acc_c   = write && !waitrequest;
        rd_acc_c   = read && !write && !waitrequest;
    end

    // Read source select, sampled into the pipeline at the acceptance edge
    always_comb begin
        rd_data_c = 32'hDEAD_BEEF;
        if (in_range_c) begin
            if (index_c == ID_IDX) begin
                rd_data_c = ID_VALUE;
            end else if (index_c == CNT_IDX) begin
                rd_data_c = cycle_cnt;
`ifdef CONSOLE_CSR_ERRCNT_EN
            end else if (index_c == ERR_IDX) begin
                rd_data_c = {16'h0000, err_cnt};
`endif
            end else begin
                rd_data_c = regs[index_c];
            end
        end
    end

    // Post-reset init window; waitrequest drops once the counter reaches zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_cnt    <= 8'(INIT_CYCLES);
            waitrequest <= 1'b1;
        end else if (init_cnt != 8'd0) begin
            init_cnt    <= init_cnt - 8'd1;
            waitrequest <= (init_cnt != 8'd1);
        end else begin
            waitrequest <= 1'b0;
        end
    end

    // Free-running cycle counter, wraps naturally
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    // Read/write registers with per-byte-lane update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_RW); i++) begin
                regs[i] <= 32'd0;
            end
        end else if (wr_acc_c && in_range_c) begin
            for (int i = 0; i < int'(NUM_RW); i++) begin
                if (index_c == IDX_W'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (byteenable[b]) begin
                            regs[i][8*b +: 8] <= writedata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

`ifdef CONSOLE_CSR_ERRCNT_EN
    // Saturating count of accepted out-of-range accesses; any write to its slot clears it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt <= 16'd0;
        end else if (wr_acc_c || rd_acc_c) begin
            if (!in_range_c) begin
                if (err_cnt != 16'hFFFF) begin
                    err_cnt <= err_cnt + 16'd1;
                end
            end else if (wr_acc_c && (index_c == ERR_IDX)) begin
                err_cnt <= 16'd0;
            end
        end
    end
`endif

    // Read pipeline; reset flushes any reads in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                pipe_data[i] <= 32'd0;
            end
        end else begin
            pipe_vld[0] <= rd_acc_c;
            if (rd_acc_c) begin
                pipe_data[0] <= rd_data_c;
            end
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    // Response register; readdata holds between valid pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata      <= 32'd0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= pipe_vld[READ_LATENCY-1];
            if (pipe_vld[READ_LATENCY-1]) begin
                readdata <= pipe_data[READ_LATENCY-1];
            end
        end
    end

    assign ctrl_out = regs[0];

endmodule

// File: tb/tb_console_csr_slave.sv
// tb_console_csr_slave: directed bench with a read scoreboard for console_csr_slave.
// Honours CONSOLE_CSR_ERRCNT_EN to model the optional out-of-range access counter.
module tb_console_csr_slave;

    localparam int unsigned LAT     = 2;
    localparam logic [31:0] ID      = 32'hC0A5_0001;
`ifdef CONSOLE_CSR_ERRCNT_EN
    localparam int unsigned NUM_RW  = 13;
`else
    localparam int unsigned NUM_RW  = 14;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] address = '0;
    logic [3:0]  byteenable = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        waitrequest;
    logic [31:0] ctrl_out;

    console_csr_slave #(
        .NUM_REGS(16), .BASE_ADDR(32'h0), .READ_LATENCY(LAT),
        .INIT_CYCLES(8), .ID_VALUE(ID)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .read(read), .write(write), .writedata(writedata), .readdata(readdata),
        .readdatavalid(readdatavalid), .waitrequest(waitrequest), .ctrl_out(ctrl_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    logic [31:0] tb_cyc;
    logic [31:0] model [14];
    logic [15:0] err_model = '0;

    // Global edge count, used to time-stamp expected responses
    always @(posedge clk) cyc <= cyc + 1;

    // Reference cycle counter: posedges since reset release
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) tb_cyc <= '0;
        else          tb_cyc <= tb_cyc + 32'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        logic [3:0] idx;
        idx = a[5:2];
        if (a[31:6] != 26'd0) return 32'hDEAD_BEEF;
        if (idx == 4'd15) return ID;
        if (idx == 4'd14) return tb_cyc;
`ifdef CONSOLE_CSR_ERRCNT_EN
        if (idx == 4'd13) return {16'h0000, err_model};
`endif
        return model[idx];
    endfunction

    function automatic void err_bump();
        if (err_model != 16'hFFFF) err_model = err_model + 16'd1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 14; i++) model[i] = '0;
        err_model = '0;
        sb.delete();
    endtask

    // One bus cycle: drive at negedge, update model / scoreboard if it will be accepted
    task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        logic [3:0] idx;
        exp_t e;
        @(negedge clk);
        read = rd; write = wr; address = a; writedata = d; byteenable = be;
        idx = a[5:2];
        if (!waitrequest) begin
            if (wr) begin
                if (a[31:6] != 26'd0) begin
                    err_bump();
                end else begin
                    if (int'(idx) < int'(NUM_RW)) begin
                        for (int b = 0; b < 4; b++)
                            if (be[b]) model[idx][8*b +: 8] = d[8*b +: 8];
                    end
`ifdef CONSOLE_CSR_ERRCNT_EN
                    if (idx == 4'd13) err_model = '0;
`endif
                end
            end else if (rd) begin
                e.data = exp_read(a);
                e.due  = cyc + 1 + LAT;
                sb.push_back(e);
                if (a[31:6] != 26'd0) err_bump();
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            read = 1'b0; write = 1'b0; byteenable = 4'h0;
        end
    endtask

    task automatic drain(input string tag);
        idle(LAT + 3);
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    // Response monitor: pop and compare data and latency on each valid
    always @(negedge clk) begin
        if (reset_n) begin
            if (readdatavalid) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", {31'd0, readdatavalid}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rdata", readdata, e.data);
                    check("latency", cyc, e.due);
                end
            end else if (sb.size() != 0 && sb[0].due < cyc) begin
                check("missing_valid", {31'd0, readdatavalid}, 32'd1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        model_reset();

        // T1: reset values and the init window
        repeat (3) @(negedge clk);
        check("rst_wait", {31'd0, waitrequest}, 32'd1);
        check("rst_valid", {31'd0, readdatavalid}, 32'd0);
        check("rst_rdata", readdata, 32'd0);
        check("rst_ctrl", ctrl_out, 32'd0);
        reset_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check("init_wait", {31'd0, waitrequest}, (k < 8) ? 32'd1 : 32'd0);
        end

        // T2: byte lanes
        drive(1'b0, 1'b1, 32'h0, 32'h1122_3344, 4'hF);
        drive(1'b0, 1'b1, 32'h0, 32'hAABB_CCDD, 4'h5);
        idle(1);
        check("ctrl_out_lanes", ctrl_out, 32'h11BB_33DD);
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        drain("t2_drain");

        // T3: back-to-back reads of ID, counter, out of range
        drive(1'b1, 1'b0, 32'h3C, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 32'h38, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        drain("t3_drain");

        // T4: read returns pre-write value, later read sees the write
        drive(1'b0, 1'b1, 32'h4, 32'h5, 4'hF);
        drive(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        drive(1'b0, 1'b1, 32'h4, 32'h9, 4'hF);
        drive(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        drain("t4_drain");

        // Zero byteenable, read-only and out-of-range writes, read+write collision, addr[1:0]
        drive(1'b0, 1'b1, 32'h8, 32'hFFFF_FFFF, 4'hF);
        drive(1'b0, 1'b1, 32'h8, 32'h0, 4'h0);
        drive(1'b0, 1'b1, 32'h38, 32'h1234_0000, 4'hF);
        drive(1'b0, 1'b1, 32'h3C, 32'h0000_5678, 4'hF);
        drive(1'b0, 1'b1, 32'h80, 32'h0BAD_0BAD, 4'hF);
        drive(1'b1, 1'b1, 32'hC, 32'h1234_5678, 4'hF);
        drive(1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 32'h3C, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 32'h39, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 32'hE, 32'h0, 4'h0);
        drive(1'b0, 1'b1, 32'h34, 32'hCAFE_F00D, 4'hF);
        drive(1'b1, 1'b0, 32'h34, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        drain("misc_drain");

        // T5: reset while a read is in flight
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        read = 1'b0;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("t5_valid", {31'd0, readdatavalid}, 32'd0);
        check("t5_rdata", readdata, 32'd0);
        check("t5_ctrl", ctrl_out, 32'd0);
        check("t5_wait", {31'd0, waitrequest}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t5_no_valid", {31'd0, readdatavalid}, 32'd0);
        end
        reset_n = 1'b1;
        idle(9);
        check("t5_wait_low", {31'd0, waitrequest}, 32'd0);
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        drain("t5_drain");

`ifdef CONSOLE_CSR_ERRCNT_EN
        // T6: out-of-range access counter
        drive(1'b0, 1'b1, 32'h100, 32'h1, 4'hF);
        drive(1'b0, 1'b1, 32'h100, 32'h2, 4'hF);
        drive(1'b0, 1'b1, 32'h100, 32'h3, 4'hF);
        drive(1'b1, 1'b0, 32'h34, 32'h0, 4'h0);
        drive(1'b0, 1'b1, 32'h34, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 32'h34, 32'h0, 4'h0);
        drain("t6_drain");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
